display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with PWM brightness and frame-synchronous
// shadow loading, so new display contents never appear partway through a frame.
module display_scan_ctrl #(
  parameter int TICK_DIV = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        OnOff,
  input  logic        LoadReq,
  input  logic [15:0] Digits,
  input  logic [3:0]  Mask,
  input  logic [3:0]  Bright,
  output logic        LoadAck,
  output logic [1:0]  Sel,
  output logic [3:0]  Nibble,
  output logic [3:0]  Cat,
  output logic        FrameStart
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam logic [15:0] TickMax = 16'(TICK_DIV - 1);

  state_e      r_state;
  state_e      w_nextState;
  logic [15:0] r_presc;
  logic [3:0]  r_tickCnt;
  logic [1:0]  r_sel;
  logic        r_frameStart;
  logic        r_loadAck;
  logic [15:0] r_digits;
  logic [3:0]  r_mask;
  logic [3:0]  r_bright;

  logic w_tick;
  logic w_capture;
  logic w_load;

  assign w_tick = (r_state != IDLE) && (r_presc == TickMax);

  // Shadows may only change while idle or at the boundary that ends digit 3.
  assign w_capture = (r_state == IDLE) ||
                     ((r_state == BLANK) && w_tick && (r_sel == 2'd3));
  assign w_load    = w_capture && LoadReq && !r_loadAck;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (OnOff) w_nextState = SCAN;
      SCAN:    if (w_tick && (r_tickCnt == 4'd14)) w_nextState = BLANK;
      BLANK:   if (w_tick) w_nextState = OnOff ? SCAN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_presc      <= 16'd0;
      r_tickCnt    <= 4'd0;
      r_sel        <= 2'd0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= 1'b0;
      case (r_state)
        IDLE: begin
          r_presc   <= 16'd0;
          r_tickCnt <= 4'd0;
          if (OnOff) begin
            r_sel        <= 2'd0;
            r_frameStart <= 1'b1;
          end
        end
        SCAN: begin
          r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
          if (w_tick) r_tickCnt <= r_tickCnt + 4'd1;
        end
        BLANK: begin
          r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
          if (w_tick) begin
            r_tickCnt <= 4'd0;
            // Sel is left alone when stopping so the last digit stays visible on Nibble.
            if (OnOff) begin
              r_sel        <= r_sel + 2'd1;
              r_frameStart <= (r_sel == 2'd3);
            end
          end
        end
        default: begin
          r_presc   <= 16'd0;
          r_tickCnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_digits  <= 16'd0;
      r_mask    <= 4'd0;
      r_bright  <= 4'd0;
      r_loadAck <= 1'b0;
    end else begin
      r_loadAck <= w_load;
      if (w_load) begin
        r_digits <= Digits;
        r_mask   <= Mask;
        r_bright <= Bright;
      end
    end
  end

  always_comb begin
    Cat    = 4'b1111;
    Nibble = r_digits[{r_sel, 2'b00} +: 4];
    if ((r_state == SCAN) && r_mask[r_sel] && (r_tickCnt < r_bright)) Cat[r_sel] = 1'b0;
  end

  assign Sel        = r_sel;
  assign LoadAck    = r_loadAck;
  assign FrameStart = r_frameStart;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: table-driven frames plus hand-written
// sequences for mid-frame loading, stopping mid-slot and asynchronous reset.
module tb_display_scan_ctrl;

  localparam int TickDiv = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        OnOff = 1'b0;
  logic        LoadReq = 1'b0;
  logic [15:0] Digits = 16'd0;
  logic [3:0]  Mask = 4'd0;
  logic [3:0]  Bright = 4'd0;
  logic        LoadAck;
  logic [1:0]  Sel;
  logic [3:0]  Nibble;
  logic [3:0]  Cat;
  logic        FrameStart;

  display_scan_ctrl #(.TICK_DIV(TickDiv)) dut (
    .Clock(Clock), .Reset(Reset), .OnOff(OnOff), .LoadReq(LoadReq),
    .Digits(Digits), .Mask(Mask), .Bright(Bright), .LoadAck(LoadAck),
    .Sel(Sel), .Nibble(Nibble), .Cat(Cat), .FrameStart(FrameStart)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string      tag;
    int         idx;
    logic [1:0] sel;
    logic [3:0] nib;
    logic [3:0] cat;
    logic       fs;
    logic       ack;
  } expT;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  mask;
    logic [3:0]  bright;
    bit          loadWithOn;
  } vecT;

  expT sbQ[$];
  vecT vecs[5];
  int  testsRun = 0;
  int  testsFailed = 0;

  function automatic logic [3:0] nibOf(input logic [15:0] d, input int slot);
    return d[slot*4 +: 4];
  endfunction

  // A slot is 64 clocks: ticks 0..14 scanning, tick 15 blanked.
  function automatic logic [3:0] catOf(input logic [3:0] m, input logic [3:0] b,
                                       input int slot, input int t);
    logic [3:0] c;
    c = 4'b1111;
    if (t < 15 && t < int'(b) && m[slot] == 1'b1) c[slot] = 1'b0;
    return c;
  endfunction

  task automatic pushExp(input string tag, input int idx, input logic [1:0] sel,
                         input logic [3:0] nib, input logic [3:0] cat,
                         input logic fs, input logic ack);
    expT e;
    e.tag = tag; e.idx = idx; e.sel = sel; e.nib = nib; e.cat = cat; e.fs = fs; e.ack = ack;
    sbQ.push_back(e);
  endtask

  task automatic pushFrame(input string tag, input logic [15:0] d, input logic [3:0] m,
                           input logic [3:0] b, input int jFrom, input int jTo, input int ackAt);
    for (int j = jFrom; j <= jTo; j++) begin
      int slot;
      int t;
      slot = (j / 64) % 4;
      t    = (j % 64) / 4;
      pushExp(tag, j, 2'(slot), nibOf(d, slot), catOf(m, b, slot, t),
              (j % 256) == 0, j == ackAt);
    end
  endtask

  task automatic checkOutput();
    expT e;
    testsRun++;
    if (sbQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty: DUT output sampled with no expectation queued");
      return;
    end
    e = sbQ.pop_front();
    if ({Sel, Nibble, Cat, FrameStart, LoadAck} !== {e.sel, e.nib, e.cat, e.fs, e.ack}) begin
      testsFailed++;
      $display("[TB] FAIL %s[%0d]: got sel=%0d nib=%h cat=%b fs=%b ack=%b, expected sel=%0d nib=%h cat=%b fs=%b ack=%b",
               e.tag, e.idx, Sel, Nibble, Cat, FrameStart, LoadAck,
               e.sel, e.nib, e.cat, e.fs, e.ack);
    end
  endtask

  task automatic applyStimulus(input logic onOff, input logic loadReq, input logic [15:0] d,
                               input logic [3:0] m, input logic [3:0] b);
    OnOff = onOff; LoadReq = loadReq; Digits = d; Mask = m; Bright = b;
  endtask

  task automatic scramble();
    Digits = 16'($urandom);
    Mask   = 4'($urandom);
    Bright = 4'($urandom);
  endtask

  task automatic runCycle();
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    Reset = 1'b0; OnOff = 1'b0; LoadReq = 1'b0;
    pushExp("reset_state", 0, 2'd0, 4'h0, 4'b1111, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    checkOutput();
    Reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'hF,    4'd15, 1'b0};
    vecs[1] = '{16'h5A0F, 4'b0101, 4'd3,  1'b0};
    vecs[2] = '{16'h9876, 4'b1010, 4'd0,  1'b1};
    vecs[3] = '{16'hFEDC, 4'b1001, 4'd1,  1'b1};
    vecs[4] = '{16'h0C3B, 4'b0110, 4'd8,  1'b0};

    // One full frame per vector, stopped during digit 3 so it ends idle on Sel 3.
    for (int v = 0; v < 5; v++) begin
      doReset();
      if (!vecs[v].loadWithOn) begin
        applyStimulus(1'b0, 1'b1, vecs[v].digits, vecs[v].mask, vecs[v].bright);
        pushExp("preload_ack", v, 2'd0, nibOf(vecs[v].digits, 0), 4'b1111, 1'b0, 1'b1);
        runCycle();
        LoadReq = 1'b0;
        scramble();
        pushExp("preload_idle", v, 2'd0, nibOf(vecs[v].digits, 0), 4'b1111, 1'b0, 1'b0);
        runCycle();
        OnOff = 1'b1;
        pushFrame($sformatf("vec%0d_frame", v), vecs[v].digits, vecs[v].mask,
                  vecs[v].bright, 0, 255, -1);
      end else begin
        applyStimulus(1'b1, 1'b1, vecs[v].digits, vecs[v].mask, vecs[v].bright);
        pushFrame($sformatf("vec%0d_frame", v), vecs[v].digits, vecs[v].mask,
                  vecs[v].bright, 0, 255, 0);
      end
      for (int k = 0; k < 3; k++)
        pushExp($sformatf("vec%0d_idle", v), k, 2'd3, nibOf(vecs[v].digits, 3),
                4'b1111, 1'b0, 1'b0);
      for (int j = 0; j < 259; j++) begin
        runCycle();
        if (j == 0) begin
          LoadReq = 1'b0;
          scramble();
        end
        if (j == 200) OnOff = 1'b0;
      end
    end

    // A request held past its acknowledge is captured again, never back to back.
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h0007, 4'h1, 4'h2);
    pushExp("hold_req", 1, 2'd0, 4'h7, 4'b1111, 1'b0, 1'b1);
    runCycle();
    Digits = 16'h0008;
    pushExp("hold_req", 2, 2'd0, 4'h7, 4'b1111, 1'b0, 1'b0);
    runCycle();
    pushExp("hold_req", 3, 2'd0, 4'h8, 4'b1111, 1'b0, 1'b1);
    runCycle();
    LoadReq = 1'b0;
    pushExp("hold_req", 4, 2'd0, 4'h8, 4'b1111, 1'b0, 1'b0);
    runCycle();

    // Mid-frame request waits for the end of digit 3, then stop during digit 2 tick 5.
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'hF, 4'd15);
    pushExp("seqA_load", 0, 2'd0, 4'h4, 4'b1111, 1'b0, 1'b1);
    runCycle();
    LoadReq = 1'b0;
    OnOff = 1'b1;
    pushFrame("seqA_old", 16'h1234, 4'hF, 4'd15, 0, 255, -1);
    pushFrame("seqA_new", 16'hABCD, 4'hF, 4'd15, 256, 447, 256);
    for (int k = 0; k < 4; k++) pushExp("seqA_idle", k, 2'd2, 4'hB, 4'b1111, 1'b0, 1'b0);
    for (int j = 0; j < 452; j++) begin
      runCycle();
      if (j == 80) applyStimulus(1'b1, 1'b1, 16'hABCD, 4'hF, 4'd15);
      if (j == 256) begin
        LoadReq = 1'b0;
        scramble();
      end
      if (j == 404) OnOff = 1'b0;
    end

    // Asynchronous reset during digit 1, then restart with cleared shadows.
    OnOff = 1'b1;
    pushFrame("seqB_run", 16'hABCD, 4'hF, 4'd15, 0, 73, -1);
    for (int j = 0; j < 74; j++) runCycle();
    #2;
    Reset = 1'b0;
    #1;
    pushExp("async_reset", 0, 2'd0, 4'h0, 4'b1111, 1'b0, 1'b0);
    checkOutput();
    #2;
    Reset = 1'b1;
    pushFrame("seqB_restart", 16'h0000, 4'h0, 4'd0, 0, 79, -1);
    for (int j = 0; j < 80; j++) runCycle();
    OnOff = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
